// File: rtl/matvec3_out_stage_if.sv
// matvec3_out_stage_if: input/output handshake bundle between the multiplier, the output stage and its consumer
interface matvec3_out_stage_if #(parameter int OUT_W = 16);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [27:0]      in_data;
    logic                    relu_en;
    logic                    vec_restart;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_last;
    logic [7:0]              sat_count;
    modport master (
        output in_valid, in_data, relu_en, vec_restart, out_ready,
        input  in_ready, out_valid, out_data, out_last, sat_count
    );
    modport slave (
        input  in_valid, in_data, relu_en, vec_restart, out_ready,
        output in_ready, out_valid, out_data, out_last, sat_count
    );
endinterface

// File: rtl/matvec3_out_stage.sv
// matvec3_out_stage: ReLU + saturation of multiplier results, last-of-vector tagging and a small output FIFO
module matvec3_out_stage #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    matvec3_out_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [28:0] MAXV = 29'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [28:0] MINV = 29'(-(1 << (OUT_W - 1)));

    logic [OUT_W:0]     mem [DEPTH];
    logic [AW-1:0]      wp, rp;
    logic [AW:0]        count;
    logic [1:0]         idx;
    logic [7:0]         sat_q;
    logic signed [28:0] r;
    logic               hi, lo, acc, pop;
    logic [OUT_W-1:0]   cdata;

    assign bus.in_ready  = count < (AW + 1)'(DEPTH);
    assign bus.out_valid = count != '0;
    assign bus.out_data  = mem[rp][OUT_W-1:0];
    assign bus.out_last  = mem[rp][OUT_W];
    assign bus.sat_count = sat_q;

    // Condition the incoming result: optional ReLU, then clamp to the signed OUT_W range
    always_comb begin
        acc   = bus.in_valid && bus.in_ready;
        pop   = bus.out_valid && bus.out_ready;
        r     = (bus.relu_en && bus.in_data[27]) ? '0 : {bus.in_data[27], bus.in_data};
        hi    = r > MAXV;
        lo    = r < MINV;
        cdata = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
    end

    // FIFO storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (acc) begin
                mem[wp] <= {idx == 2'd2, cdata};
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW + 1)'(acc) - (AW + 1)'(pop);
        end
    end

    // Element index within the 3-element vector and the saturating clamp counter
    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            sat_q <= '0;
        end else begin
            idx   <= bus.vec_restart ? 2'd0 : !acc ? idx : (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            sat_q <= (acc && (hi || lo) && sat_q != 8'hff) ? sat_q + 8'd1 : sat_q;
        end
    end
endmodule

// File: tb/tb_matvec3_out_stage.sv
// tb_matvec3_out_stage: directed scoreboard bench for the conditioning/FIFO output stage
module tb_matvec3_out_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   eidx = 0;
    logic [16:0] sb[$];

    matvec3_out_stage_if #(.OUT_W(16)) bus();

    matvec3_out_stage #(.OUT_W(16), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one element; expected entry is queued once the bench sees in_ready high before the edge
    task automatic send(input logic signed [27:0] d, input logic relu, input logic rst_idx,
                        input logic signed [15:0] ed);
        int n;
        n = 0;
        bus.in_valid    = 1'b1;
        bus.in_data     = d;
        bus.relu_en     = relu;
        bus.vec_restart = rst_idx;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for data %0d, required 1", d);
        end else begin
            sb.push_back({eidx == 2, ed});
            eidx = rst_idx ? 0 : (eidx == 2 ? 0 : eidx + 1);
        end
        @(posedge clk);
        #1;
        bus.vec_restart = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid    = 1'b0;
        bus.vec_restart = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        eidx         = 0;
    endtask

    // Monitor: every pop the DUT presents is compared against the scoreboard head
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: data=%0d last=%0d with nothing expected",
                         bus.out_data, bus.out_last);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                if (e != {bus.out_last, bus.out_data}) begin
                    errors++;
                    $display("FAIL output: data=%0d last=%0d expected data=%0d last=%0d",
                             bus.out_data, bus.out_last, $signed(e[15:0]), e[16]);
                end
            end
        end
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.relu_en     = 1'b0;
        bus.vec_restart = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_out_data", int'(bus.out_data), 0);
        check("reset_sat_count", int'(bus.sat_count), 0);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        send(28'sd100, 1'b0, 1'b0, 16'sd100);
        check("latency_out_valid", int'(bus.out_valid), 1);
        check("latency_out_data", int'(bus.out_data), 100);
        send(-28'sd5, 1'b0, 1'b0, -16'sd5);
        send(28'sd7, 1'b0, 1'b0, 16'sd7);
        idle(3);
        check("stream_drained", int'(bus.out_valid), 0);
        check("stream_sat_count", int'(bus.sat_count), 0);

        send(-28'sd1, 1'b1, 1'b0, 16'sd0);
        send(-28'sd134217728, 1'b1, 1'b0, 16'sd0);
        send(28'sd32767, 1'b1, 1'b0, 16'sd32767);
        idle(3);
        check("relu_sat_count", int'(bus.sat_count), 0);

        send(28'sd40000, 1'b0, 1'b0, 16'sd32767);
        send(-28'sd40000, 1'b0, 1'b0, -16'sd32768);
        send(28'sd32768, 1'b0, 1'b0, 16'sd32767);
        send(-28'sd32769, 1'b0, 1'b0, -16'sd32768);
        idle(3);
        check("clamp_sat_count", int'(bus.sat_count), 4);
        for (int i = 0; i < 296; i++) send(28'sd40000, 1'b0, 1'b0, 16'sd32767);
        idle(3);
        check("sat_count_saturated", int'(bus.sat_count), 255);

        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(28'(i), 1'b0, 1'b0, 16'(i));
        bus.in_valid = 1'b1;
        bus.in_data  = 28'sd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_head_valid", int'(bus.out_valid), 1);
            check("bp_head_data", int'(bus.out_data), 1);
            check("bp_head_last", int'(bus.out_last), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(28'sd5, 1'b0, 1'b0, 16'sd5);
        send(28'sd6, 1'b0, 1'b0, 16'sd6);
        idle(8);
        check("bp_drained", int'(bus.out_valid), 0);

        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 10; i <= 13; i++) send(28'(i), 1'b0, 1'b0, 16'(i));
        bus.in_valid  = 1'b1;
        bus.in_data   = 28'sd14;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_pop_next_ready", int'(bus.in_ready), 1);
        idle(6);
        check("full_drained", int'(bus.out_valid), 0);

        do_reset();
        bus.out_ready = 1'b1;
        send(28'sd21, 1'b0, 1'b0, 16'sd21);
        send(28'sd22, 1'b0, 1'b0, 16'sd22);
        send(28'sd23, 1'b0, 1'b1, 16'sd23);
        send(28'sd24, 1'b0, 1'b0, 16'sd24);
        idle(4);

        bus.out_ready = 1'b0;
        send(28'sd31, 1'b0, 1'b0, 16'sd31);
        send(28'sd32, 1'b0, 1'b0, 16'sd32);
        check("pre_reset_valid", int'(bus.out_valid), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 28'sd33;
        do_reset();
        @(negedge clk);
        check("mid_reset_out_valid", int'(bus.out_valid), 0);
        check("mid_reset_in_ready", int'(bus.in_ready), 1);
        check("mid_reset_out_data", int'(bus.out_data), 0);
        bus.out_ready = 1'b1;
        idle(3);
        check("mid_reset_stays_empty", int'(bus.out_valid), 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matvec3_out_stage.md
# matvec3_out_stage

Output conditioning and buffering stage placed directly downstream of the 3x3 matrix-vector multiplier. It consumes the multiplier's signed 28-bit result stream over a valid/ready handshake. It optionally applies ReLU and saturates each result to a narrower signed width. It tags the last element of every 3-element output vector and buffers results in a small FIFO, so that a stalled consumer does not immediately back-pressure the multiplier.

## Interface
- OUT_W, 16: output data width; signed; 2 <= OUT_W <= 28.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  multiplier result valid (driven by multiplier output_valid).
- in_ready  out  1  stage can accept (drives multiplier output_ready).
- in_data  in  28  signed multiplier result.
- relu_en  in  1  1 = negative results forced to 0 before saturation; sampled per accepted element.
- vec_restart  in  1  1-cycle pulse; resets element index to 0 (aligns to the multiplier's new_matrix).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  OUT_W  signed conditioned result at FIFO head.
- out_last  out  1  head is element 2 (last) of a 3-element vector.
- sat_count  out  8  number of accepted elements that were clamped; saturates at 255.

## Operation
- Accept: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Conditioning, applied combinationally on in_data at accept:
  - r = (relu_en && in_data < 0) ? 0 : in_data.
  - If r > 2^(OUT_W-1)-1, store 2^(OUT_W-1)-1.
  - If r < -2^(OUT_W-1), store -2^(OUT_W-1).
  - Otherwise store r[OUT_W-1:0].
  - clamped = either bound was hit. ReLU zeroing alone is not counted as clamped.
- Element index idx, 2 bits, cycles 0,1,2,0 and advances on each accept. The last flag stored with an entry is (idx == 2). There is no state for idx == 3.
- vec_restart forces idx to 0 next cycle.
  - If vec_restart and an accept occur in the same cycle, the accepted element is tagged with the current idx, and idx becomes 0 afterwards (vec_restart wins over the increment).
- FIFO: circular buffer of DEPTH entries of {last, data}.
  - Write pointer, read pointer and an occupancy count 0..DEPTH.
  - Pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH). This is combinational from registered count only and has no dependency on out_ready.
  - When full, no accept occurs even if a pop happens in the same cycle.
- out_valid = (count > 0). out_data and out_last are driven from the read-pointer entry.
- Push and pop in the same cycle (count neither 0 nor DEPTH): count unchanged, both pointers advance.
- Pop when empty and push when full are impossible by construction.
- sat_count increments by 1 on each accept with clamped = 1 and holds at 255.

## Timing
- Reset (synchronous, takes effect on the clk edge where reset = 1):
  - count = 0, pointers = 0, idx = 0, sat_count = 0.
  - Therefore out_valid = 0 and in_ready = 1 in the cycle after the reset edge.
  - out_data reads the stored entry; it is don't-care while out_valid = 0, but the bench requires 0 after reset (FIFO storage is cleared on reset).
- Reset mid-operation discards all buffered entries. An accept or pop in the reset cycle has no effect.
- Latency: an element accepted at edge N is visible at the head with out_valid = 1 after edge N, when the FIFO was empty. There is no combinational in-to-out path.
- Throughput: 1 element per cycle sustained while out_ready = 1.
- With out_ready held 0, exactly DEPTH elements are accepted, then in_ready = 0 until the first pop.
- Holding rule: out_data, out_last and out_valid remain stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset then a 3-element stream 100, -5, 7 with relu_en = 0 and out_ready = 1:
  - out_data is 100, -5, 7 on consecutive cycles, each 1 cycle after its accept.
  - out_last = 0, 0, 1.
  - sat_count = 0.
- relu_en = 1, inputs -1, -134217728, 32767 (OUT_W = 16):
  - outputs 0, 0, 32767.
  - sat_count = 0.
- relu_en = 0, inputs 40000, -40000, 32768, -32769:
  - outputs 32767, -32768, 32767, -32768.
  - sat_count = 4.
  - After 300 such inputs, sat_count = 255.
- Back-pressure, out_ready = 0, 6 inputs offered:
  - 4 are accepted, then in_ready = 0 with the head stable.
  - Raising out_ready drains all 6 in order.
  - The last flags follow the 0,1,2 pattern across the 6 elements: 0,0,1,0,0,1.
- Full FIFO with simultaneous in_valid and out_ready:
  - the pop occurs and no accept occurs in that cycle.
  - in_ready = 1 in the next cycle.
- Accept 2 elements, then pulse vec_restart together with a 3rd accept:
  - the 3rd element has out_last = 1 (idx was 2).
  - The next accepted element has out_last = 0 (idx restarted at 0).
  - Asserting reset while the FIFO is non-empty gives out_valid = 0 and in_ready = 1 in the next cycle.
